// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one read request at a time and returns
// the big-endian halfword at the latched address after a fixed latency.
module imem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [15:0]           req_addr,
    output logic                  req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [7:0]            instruction_code_high,
    output logic [7:0]            instruction_code_low,
    output logic                  resp_err,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [7:0]            load_data
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0]            WAIT_LOAD = 4'(LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    logic [7:0]            mem_r [DEPTH];
    logic [1:0]            state_r;
    logic [1:0]            state_s;
    logic [3:0]            count_r;
    logic [3:0]            count_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s;
    logic [7:0]            rd_high_s;
    logic [7:0]            rd_low_s;
    logic                  misalign_s;
    logic                  enter_resp_s;
    logic                  resp_valid_s;
    logic                  resp_err_s;
    logic                  req_ready_s;
    logic [7:0]            high_s;
    logic [7:0]            low_s;
    logic                  unused_addr_s;

    assign unused_addr_s = ^req_addr[15:ADDR_WIDTH];

    // Read port: in IDLE the incoming address feeds the read so LATENCY=1 can capture on acceptance.
    always_comb begin
        if (state_r == ST_IDLE) begin
            rd_addr_s = req_addr[ADDR_WIDTH-1:0];
        end else begin
            rd_addr_s = addr_r;
        end
        rd_high_s  = mem_r[rd_addr_s];
        rd_low_s   = mem_r[rd_addr_s + ADDR_ONE];
        misalign_s = rd_addr_s[0];
    end

    // Next-state and response-capture logic.
    always_comb begin
        state_s      = state_r;
        count_s      = count_r;
        addr_s       = addr_r;
        resp_valid_s = resp_valid;
        resp_err_s   = resp_err;
        high_s       = instruction_code_high;
        low_s        = instruction_code_low;
        enter_resp_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_s = req_addr[ADDR_WIDTH-1:0];
                    if (LATENCY == 1) begin
                        enter_resp_s = 1'b1;
                    end else begin
                        state_s = ST_WAIT;
                        count_s = WAIT_LOAD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (count_r == 4'd0) begin
                    enter_resp_s = 1'b1;
                end else begin
                    count_s = count_r - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_s      = ST_IDLE;
                    resp_valid_s = 1'b0;
                    resp_err_s   = 1'b0;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s      = ST_IDLE;
                count_s      = 4'd0;
                resp_valid_s = 1'b0;
                resp_err_s   = 1'b0;
            end
        endcase

        // Misaligned fetches return zero data with the error flag, same timing.
        if (enter_resp_s) begin
            state_s      = ST_RESP;
            count_s      = 4'd0;
            resp_valid_s = 1'b1;
            resp_err_s   = misalign_s;
            if (misalign_s) begin
                high_s = 8'h00;
                low_s  = 8'h00;
            end else begin
                high_s = rd_high_s;
                low_s  = rd_low_s;
            end
        end else begin
            resp_valid_s = resp_valid_s;
        end

        req_ready_s = (state_s == ST_IDLE);
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r               <= ST_IDLE;
            count_r               <= 4'd0;
            addr_r                <= '0;
            req_ready             <= 1'b1;
            resp_valid            <= 1'b0;
            resp_err              <= 1'b0;
            instruction_code_high <= 8'h00;
            instruction_code_low  <= 8'h00;
        end else begin
            state_r               <= state_s;
            count_r               <= count_s;
            addr_r                <= addr_s;
            req_ready             <= req_ready_s;
            resp_valid            <= resp_valid_s;
            resp_err              <= resp_err_s;
            instruction_code_high <= high_s;
            instruction_code_low  <= low_s;
        end
    end

    // Preload port writes regardless of state or reset; memory is never cleared.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_r[load_addr] <= load_data;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder (LATENCY=2 and LATENCY=1 builds).
module tb_imem_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_en;
    logic [7:0] load_addr;
    logic [7:0] load_data;

    logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
    logic [15:0] req_addr;
    logic [7:0]  hi, lo;

    logic        req_valid1, req_ready1, resp_valid1, resp_ready1, resp_err1;
    logic [15:0] req_addr1;
    logic [7:0]  hi1, lo1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imem_responder #(.ADDR_WIDTH(8), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .instruction_code_high(hi), .instruction_code_low(lo), .resp_err(resp_err),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    imem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_addr(req_addr1), .req_ready(req_ready1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1),
        .instruction_code_high(hi1), .instruction_code_low(lo1), .resp_err(resp_err1),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    // Full request on the LATENCY=2 instance with resp_ready held high.
    task automatic do_req(input string tag, input logic [15:0] a,
                          input logic [7:0] eh, input logic [7:0] el, input logic ee);
        resp_ready = 1'b1;
        req_valid = 1'b1; req_addr = a;
        tick();
        req_valid = 1'b0;
        check_val({tag, "_rdy_wait"}, {31'd0, req_ready}, 32'd0);
        check_val({tag, "_vld_n1"}, {31'd0, resp_valid}, 32'd0);
        tick();
        check_val({tag, "_vld_n2"}, {31'd0, resp_valid}, 32'd0);
        tick();
        check_val({tag, "_vld"}, {31'd0, resp_valid}, 32'd1);
        check_val({tag, "_hi"}, {24'd0, hi}, {24'd0, eh});
        check_val({tag, "_lo"}, {24'd0, lo}, {24'd0, el});
        check_val({tag, "_err"}, {31'd0, resp_err}, {31'd0, ee});
        tick();
        check_val({tag, "_vld_done"}, {31'd0, resp_valid}, 32'd0);
        check_val({tag, "_rdy_done"}, {31'd0, req_ready}, 32'd1);
        check_val({tag, "_err_done"}, {31'd0, resp_err}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; load_en = 1'b0; load_addr = 8'h00; load_data = 8'h00;
        req_valid = 1'b0; req_addr = 16'h0000; resp_ready = 1'b0;
        req_valid1 = 1'b0; req_addr1 = 16'h0000; resp_ready1 = 1'b1;
        tick();
        load(8'h0C, 8'h00);  // load during reset still writes
        check_val("rst_ready", {31'd0, req_ready}, 32'd1);
        check_val("rst_valid", {31'd0, resp_valid}, 32'd0);
        check_val("rst_err", {31'd0, resp_err}, 32'd0);
        check_val("rst_hi", {24'd0, hi}, 32'd0);
        check_val("rst_lo", {24'd0, lo}, 32'd0);
        reset = 1'b0;
        load(8'h0D, 8'h0C);
        load(8'hFE, 8'h12); load(8'hFF, 8'hAB); load(8'h00, 8'hCD);
        load(8'h10, 8'h11); load(8'h11, 8'h22);
        load(8'h01, 8'hEF); load(8'h02, 8'h34); load(8'h03, 8'h56);
        load(8'h04, 8'h78); load(8'h05, 8'h9A);

        // 1: basic latency-2 fetch
        do_req("t1", 16'h000C, 8'h00, 8'h0C, 1'b0);

        // 2: backpressure, stray req_valid ignored
        resp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 16'h000C;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            check_val("bp_vld", {31'd0, resp_valid}, 32'd1);
            check_val("bp_hi", {24'd0, hi}, 32'h00);
            check_val("bp_lo", {24'd0, lo}, 32'h0C);
            check_val("bp_rdy", {31'd0, req_ready}, 32'd0);
            req_valid = (i == 2); req_addr = 16'h0010;
            tick();
        end
        req_valid = 1'b0;
        check_val("bp_hold", {31'd0, resp_valid}, 32'd1);
        resp_ready = 1'b1;
        tick();
        check_val("bp_release", {31'd0, resp_valid}, 32'd0);
        tick(); tick(); tick();
        check_val("bp_no_queue", {31'd0, resp_valid}, 32'd0);
        check_val("bp_idle_rdy", {31'd0, req_ready}, 32'd1);

        // 3: upper bits ignored, misaligned, aligned at top
        do_req("t3_upper", 16'h01FE, 8'h12, 8'hAB, 1'b0);
        do_req("t3_mis", 16'h00FF, 8'h00, 8'h00, 1'b1);
        do_req("t3_top", 16'h00FE, 8'h12, 8'hAB, 1'b0);

        // 4: load during WAIT is visible
        req_valid = 1'b1; req_addr = 16'h0010;
        tick();
        req_valid = 1'b0;
        load(8'h10, 8'h55);
        tick();
        check_val("race_wait_hi", {24'd0, hi}, 32'h55);
        check_val("race_wait_lo", {24'd0, lo}, 32'h22);
        tick();
        load(8'h10, 8'h11);
        // load on the RESP-entry edge returns the old byte
        req_valid = 1'b1; req_addr = 16'h0010;
        tick();
        req_valid = 1'b0;
        tick();
        load(8'h10, 8'h66);
        check_val("race_entry_vld", {31'd0, resp_valid}, 32'd1);
        check_val("race_entry_hi", {24'd0, hi}, 32'h11);
        tick();
        do_req("race_after", 16'h0010, 8'h66, 8'h22, 1'b0);

        // 5: reset during WAIT drops the request
        req_valid = 1'b1; req_addr = 16'h000C;
        tick();
        req_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("mid_rst_vld", {31'd0, resp_valid}, 32'd0);
        check_val("mid_rst_rdy", {31'd0, req_ready}, 32'd1);
        check_val("mid_rst_hi", {24'd0, hi}, 32'd0);
        check_val("mid_rst_lo", {24'd0, lo}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("mid_rst_stale", {31'd0, resp_valid}, 32'd0);
        end
        do_req("mid_rst_mem", 16'h0010, 8'h66, 8'h22, 1'b0);

        // 6: LATENCY=1 back-to-back stream
        req_valid1 = 1'b1; req_addr1 = 16'h0000;
        tick();
        check_val("l1_a0_vld", {31'd0, resp_valid1}, 32'd1);
        check_val("l1_a0_hi", {24'd0, hi1}, 32'hCD);
        check_val("l1_a0_lo", {24'd0, lo1}, 32'hEF);
        req_addr1 = 16'h0002;
        tick();
        check_val("l1_gap1", {31'd0, resp_valid1}, 32'd0);
        check_val("l1_gap1_rdy", {31'd0, req_ready1}, 32'd1);
        tick();
        check_val("l1_a2_vld", {31'd0, resp_valid1}, 32'd1);
        check_val("l1_a2_hi", {24'd0, hi1}, 32'h34);
        check_val("l1_a2_lo", {24'd0, lo1}, 32'h56);
        req_addr1 = 16'h0004;
        tick();
        check_val("l1_gap2", {31'd0, resp_valid1}, 32'd0);
        tick();
        check_val("l1_a4_vld", {31'd0, resp_valid1}, 32'd1);
        check_val("l1_a4_hi", {24'd0, hi1}, 32'h78);
        check_val("l1_a4_lo", {24'd0, lo1}, 32'h9A);
        check_val("l1_a4_err", {31'd0, resp_err1}, 32'd0);
        req_valid1 = 1'b0;
        tick();
        check_val("l1_end", {31'd0, resp_valid1}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
